register_tree_kv: RTL and testbench

- Parametrised successor of the cycled register-tree priority queue.
- Stores key/payload pairs in a complete binary tree of registers, kept in heap order by alternating-level compare-swap.
- Selectable max-first or min-first ordering, with a ready handshake, an occupancy count and an error pulse.
- Sits in front of schedulers that need the highest-priority tagged item each few cycles.

---
 rtl/register_tree_kv.sv | 137 +++++++++++++
 tb/tb_register_tree_kv.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_tree_kv.sv
// ============================================================================
// register_tree_kv -- heap-ordered key/payload priority queue built from a
// register tree sorted by alternating-level compare-swap.   Revision 1.0
// ============================================================================
`default_nettype none

module register_tree_kv #(
  parameter int   LEVELS    = 4,
  parameter int   KEY_WIDTH = 16,
  parameter int   VAL_WIDTH = 8,
  parameter logic MIN_FIRST = 1'b0,
  parameter logic ENQ_ENA   = 1'b1
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic                 i_wrt,
  input  logic                 i_read,
  input  logic [KEY_WIDTH-1:0] i_key,
  input  logic [VAL_WIDTH-1:0] i_val,
  output logic                 o_ready,
  output logic [KEY_WIDTH-1:0] o_key,
  output logic [VAL_WIDTH-1:0] o_val,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [LEVELS-1:0]    o_count,
  output logic                 o_err
);

  localparam int QUEUE_SIZE = (1 << LEVELS) - 1;
  localparam int BUSY_W     = $clog2(LEVELS + 1);

  typedef struct packed {
    logic                 vld;
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } node_t;

  node_t nodes   [QUEUE_SIZE];
  node_t staged  [QUEUE_SIZE];
  node_t swapped [QUEUE_SIZE];

  logic [LEVELS-1:0] count, count_nxt, last;
  logic [BUSY_W-1:0] busy, busy_nxt;
  logic              phase, err;
  logic              full, empty, accept, do_enq, do_deq, do_rep, bad;
  logic [LEVELS-1:0] par, lch, rch, win;

  // Invalid nodes always lose; equal keys never displace the parent.
  function automatic logic beats(input node_t a, input node_t b);
    if (!a.vld) return 1'b0;
    if (!b.vld) return 1'b1;
    return MIN_FIRST ? (a.key < b.key) : (a.key > b.key);
  endfunction

  assign full   = (count == LEVELS'(QUEUE_SIZE));
  assign empty  = (count == '0);
  assign last   = count - 1'b1;
  assign accept = o_ready & (i_wrt | i_read);
  assign do_enq = accept & i_wrt & ~i_read & ~full & ENQ_ENA;
  assign do_deq = accept & i_read & ~i_wrt & ~empty;
  assign do_rep = accept & i_wrt & i_read;
  assign bad    = accept & ((i_wrt & ~i_read & (full | ~ENQ_ENA)) |
                            (i_read & ~i_wrt & empty));

  always_comb begin
    staged    = nodes;
    count_nxt = count;
    busy_nxt  = (busy != '0) ? busy - 1'b1 : '0;
    if (do_enq) begin
      staged[count] = {1'b1, i_key, i_val};
      count_nxt     = count + 1'b1;
      busy_nxt      = BUSY_W'(LEVELS);
    end else if (do_deq) begin
      // With a single entry last == 0, so the second write clears the root.
      staged[0]    = nodes[last];
      staged[last] = '0;
      count_nxt    = last;
      busy_nxt     = BUSY_W'(2);
    end else if (do_rep) begin
      staged[0] = {1'b1, i_key, i_val};
      if (empty) count_nxt = LEVELS'(1);
      busy_nxt  = BUSY_W'(2);
    end
  end

  // Compare-swap runs on the post-operation image so sorting never pauses.
  always_comb begin
    swapped = staged;
    par     = '0;
    lch     = '0;
    rch     = '0;
    win     = '0;
    for (int lv = 0; lv < LEVELS - 1; lv++) begin
      if (phase == lv[0]) begin
        for (int j = 0; j < (1 << lv); j++) begin
          par = LEVELS'((1 << lv) - 1 + j);
          lch = LEVELS'(2 * ((1 << lv) - 1 + j) + 1);
          rch = LEVELS'(2 * ((1 << lv) - 1 + j) + 2);
          win = par;
          if (beats(staged[lch], staged[win])) win = lch;
          if (beats(staged[rch], staged[win])) win = rch;
          if (win != par) begin
            swapped[par] = staged[win];
            swapped[win] = staged[par];
          end
        end
      end
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      for (int i = 0; i < QUEUE_SIZE; i++) nodes[i] <= '0;
      count <= '0;
      busy  <= '0;
      phase <= 1'b0;
      err   <= 1'b0;
    end else begin
      nodes <= swapped;
      count <= count_nxt;
      busy  <= busy_nxt;
      phase <= ~phase;
      err   <= bad;
    end
  end

  assign o_ready = (busy == '0);
  assign o_key   = nodes[0].vld ? nodes[0].key : '0;
  assign o_val   = nodes[0].vld ? nodes[0].val : '0;
  assign o_full  = full;
  assign o_empty = empty;
  assign o_count = count;
  assign o_err   = err;

endmodule

`default_nettype wire

// File: tb/tb_register_tree_kv.sv
// ============================================================================
// tb_register_tree_kv -- scoreboard bench for register_tree_kv (max-first and
// min-first/no-enqueue instances).   Revision 1.0
// ============================================================================
`default_nettype none

module tb_register_tree_kv;

  logic clk;
  logic rst;
  logic wrt, rd, sel;
  logic [15:0] key;
  logic [7:0]  val;

  logic        wrt0, rd0, wrt1, rd1;
  logic        ready0, full0, empty0, err0, ready1, full1, empty1, err1;
  logic [15:0] key0, key1;
  logic [7:0]  val0, val1;
  logic [3:0]  count0, count1;

  logic        m_ready, m_full, m_empty, m_err;
  logic [15:0] m_key;
  logic [7:0]  m_val;
  logic [3:0]  m_count;

  assign wrt0 = wrt & ~sel;
  assign rd0  = rd & ~sel;
  assign wrt1 = wrt & sel;
  assign rd1  = rd & sel;

  assign m_ready = sel ? ready1 : ready0;
  assign m_full  = sel ? full1  : full0;
  assign m_empty = sel ? empty1 : empty0;
  assign m_err   = sel ? err1   : err0;
  assign m_key   = sel ? key1   : key0;
  assign m_val   = sel ? val1   : val0;
  assign m_count = sel ? count1 : count0;

  register_tree_kv #(.LEVELS(4), .KEY_WIDTH(16), .VAL_WIDTH(8),
                     .MIN_FIRST(1'b0), .ENQ_ENA(1'b1)) dut (
    .i_CLK(clk), .i_RST(rst), .i_wrt(wrt0), .i_read(rd0),
    .i_key(key), .i_val(val), .o_ready(ready0), .o_key(key0),
    .o_val(val0), .o_full(full0), .o_empty(empty0), .o_count(count0),
    .o_err(err0)
  );

  register_tree_kv #(.LEVELS(4), .KEY_WIDTH(16), .VAL_WIDTH(8),
                     .MIN_FIRST(1'b1), .ENQ_ENA(1'b0)) dut_min (
    .i_CLK(clk), .i_RST(rst), .i_wrt(wrt1), .i_read(rd1),
    .i_key(key), .i_val(val), .o_ready(ready1), .o_key(key1),
    .o_val(val1), .o_full(full1), .o_empty(empty1), .o_count(count1),
    .o_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] key;
    logic [7:0]  val;
    int          count;
    logic        err;
  } exp_t;

  typedef struct {
    logic [15:0] key;
    logic [7:0]  val;
  } item_t;

  exp_t  exp_q[$];
  item_t model[$];
  int    tests = 0;
  int    fails = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  function automatic int best_idx();
    int bi;
    bi = -1;
    for (int i = 0; i < model.size(); i++)
      if (bi < 0 || (sel ? (model[i].key < model[bi].key) : (model[i].key > model[bi].key)))
        bi = i;
    return bi;
  endfunction

  function automatic logic [15:0] fresh_key();
    logic [15:0] k;
    bit dup;
    k = 16'd1;
    for (int t = 0; t < 100; t++) begin
      k = 16'($urandom_range(1, 65535));
      dup = 0;
      foreach (model[i]) if (model[i].key == k) dup = 1;
      if (!dup) return k;
    end
    return k;
  endfunction

  task automatic do_op(input logic w, input logic r, input logic [15:0] k,
                       input logic [7:0] v, input bit rst_mid);
    exp_t e;
    int   bi, n;
    bit   is_full, is_empty;
    is_full  = (model.size() == 15);
    is_empty = (model.size() == 0);
    e.err    = 1'b0;
    if (rst_mid) begin
      model.delete();
    end else if (w && !r) begin
      if (is_full || sel) e.err = 1'b1;
      else model.push_back('{k, v});
    end else if (r && !w) begin
      if (is_empty) e.err = 1'b1;
      else model.delete(best_idx());
    end else if (w && r) begin
      if (!is_empty) model.delete(best_idx());
      model.push_back('{k, v});
    end
    bi      = best_idx();
    e.key   = (bi < 0) ? 16'd0 : model[bi].key;
    e.val   = (bi < 0) ? 8'd0  : model[bi].val;
    e.count = model.size();
    exp_q.push_back(e);

    @(negedge clk);
    n = 0;
    while (!m_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!m_ready) begin
      tests++;
      fails++;
      $display("FAIL drv_ready_timeout: got ready=0, want ready=1");
    end
    wrt = w;
    rd  = r;
    key = k;
    val = v;
    @(posedge clk);
    @(negedge clk);
    wrt = 1'b0;
    rd  = 1'b0;
    if (rst_mid) begin
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  exp_t mon_e;
  int   mon_n;
  logic mon_err;

  initial begin : monitor
    forever begin
      @(posedge clk);
      if (m_ready && (wrt || rd) && !rst) begin
        @(negedge clk);
        mon_err = m_err;
        mon_n = 0;
        while (!m_ready && mon_n < 50) begin
          @(negedge clk);
          mon_n++;
        end
        if (mon_n >= 50) begin
          tests++;
          fails++;
          $display("FAIL mon_ready_timeout: got ready=0, want ready=1");
        end
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL mon_unexpected: got response, want none queued");
        end else begin
          mon_e = exp_q.pop_front();
          chk("op_err",   32'(mon_err),   32'(mon_e.err));
          chk("op_key",   32'(m_key),     32'(mon_e.key));
          chk("op_val",   32'(m_val),     32'(mon_e.val));
          chk("op_count", 32'(m_count),   32'(mon_e.count));
          chk("op_empty", 32'(m_empty),   32'(mon_e.count == 0));
          chk("op_full",  32'(m_full),    32'(mon_e.count == 15));
        end
      end
    end
  end

  logic prev_err = 1'b0;
  always @(negedge clk) begin
    if (prev_err) chk("err_one_cycle", 32'(m_err), 32'd0);
    prev_err <= m_err;
  end

  logic [15:0] dkeys [5];
  initial begin
    rst = 1'b1;
    wrt = 1'b0;
    rd  = 1'b0;
    key = '0;
    val = '0;
    sel = 1'b0;
    dkeys[0] = 16'd5;
    dkeys[1] = 16'd900;
    dkeys[2] = 16'd42;
    dkeys[3] = 16'd900;
    dkeys[4] = 16'd7;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_empty", 32'(empty0), 32'd1);
    chk("rst_full",  32'(full0),  32'd0);
    chk("rst_count", 32'(count0), 32'd0);
    chk("rst_key",   32'(key0),   32'd0);
    chk("rst_val",   32'(val0),   32'd0);
    chk("rst_ready", 32'(ready0), 32'd1);
    chk("rst_err",   32'(err0),   32'd0);
    chk("rst_ready_min", 32'(ready1), 32'd1);

    // Duplicate 900s: the earlier one stays at the root until removed.
    for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, dkeys[i], 8'(i + 1), 1'b0);
    for (int i = 0; i < 5; i++) do_op(1'b0, 1'b1, 16'd0, 8'd0, 1'b0);

    for (int i = 0; i < 15; i++) do_op(1'b1, 1'b0, fresh_key(), 8'($urandom), 1'b0);
    do_op(1'b1, 1'b0, 16'd1234, 8'hAA, 1'b0);
    for (int i = 0; i < 7; i++) do_op(1'b1, 1'b1, fresh_key(), 8'($urandom), 1'b0);
    for (int i = 0; i < 15; i++) do_op(1'b0, 1'b1, 16'd0, 8'd0, 1'b0);
    do_op(1'b0, 1'b1, 16'd0, 8'd0, 1'b0);
    drain();

    sel = 1'b1;
    do_op(1'b1, 1'b0, 16'd3,  8'h03, 1'b0);
    do_op(1'b1, 1'b1, 16'd30, 8'h1E, 1'b0);
    do_op(1'b1, 1'b1, 16'd10, 8'h0A, 1'b0);
    do_op(1'b1, 1'b1, 16'd20, 8'h14, 1'b0);
    do_op(1'b0, 1'b1, 16'd0,  8'd0,  1'b0);
    drain();
    sel = 1'b0;

    for (int op = 0; op < 200; op++) begin
      if (op == 100) begin
        if (model.size() == 15) do_op(1'b0, 1'b1, 16'd0, 8'd0, 1'b0);
        do_op(1'b1, 1'b0, fresh_key(), 8'($urandom), 1'b1);
      end else begin
        case ($urandom_range(0, 2))
          0:       do_op(1'b1, 1'b0, fresh_key(), 8'($urandom), 1'b0);
          1:       do_op(1'b0, 1'b1, 16'd0, 8'd0, 1'b0);
          default: do_op(1'b1, 1'b1, fresh_key(), 8'($urandom), 1'b0);
        endcase
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
